// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared op codes, FSM state encodings and op-classification helpers for the
// HI/LO multiply/divide unit.
package hilo_muldiv_unit_pkg;

    localparam int MD_OP_LENGTH = 4;

    typedef enum logic [MD_OP_LENGTH-1:0] {
        MD_OP_NONE  = 4'd0,
        MD_OP_MULT  = 4'd1,
        MD_OP_MULTU = 4'd2,
        MD_OP_DIV   = 4'd3,
        MD_OP_DIVU  = 4'd4,
        MD_OP_MTHI  = 4'd5,
        MD_OP_MTLO  = 4'd6,
        MD_OP_MFHI  = 4'd7,
        MD_OP_MFLO  = 4'd8
    } md_op_e;

    typedef enum logic [1:0] {
        MD_ST_IDLE  = 2'd0,
        MD_ST_RUN   = 2'd1,
        MD_ST_FIXUP = 2'd2
    } md_state_e;

    function automatic logic isMulDivOp(input logic [MD_OP_LENGTH-1:0] op);
        return (op == MD_OP_MULT) || (op == MD_OP_MULTU) ||
               (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
    endfunction

    function automatic logic isDivOp(input logic [MD_OP_LENGTH-1:0] op);
        return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
    endfunction

    function automatic logic isSignedOp(input logic [MD_OP_LENGTH-1:0] op);
        return (op == MD_OP_MULT) || (op == MD_OP_DIV);
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_iter_core.sv
// One-bit-per-cycle shift-add multiplier / restoring divider on operand
// magnitudes, with its own iteration counter.
module md_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               signed_i,
    input  logic               is_div_i,
    input  logic               run_i,
    input  logic               clear_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               step_done_o,
    output logic               neg_a_o,
    output logic               neg_b_o,
    output logic [2*WIDTH-1:0] result_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] accHi_q, accHi_d;
    logic [WIDTH-1:0] accLo_q, accLo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             negA_q, negA_d;
    logic             negB_q, negB_d;
    logic             isDiv_q, isDiv_d;

    logic [WIDTH-1:0] absA, absB;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divTrial;
    logic [WIDTH:0]   divDiff;
    logic             divGe;

    assign absA = (signed_i && a_i[WIDTH-1]) ? (~a_i + 1'b1) : a_i;
    assign absB = (signed_i && b_i[WIDTH-1]) ? (~b_i + 1'b1) : b_i;

    assign mulSum   = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, opnd_q} : '0);
    assign divTrial = {accHi_q, accLo_q[WIDTH-1]};
    assign divDiff  = divTrial - {1'b0, opnd_q};
    assign divGe    = (divTrial >= {1'b0, opnd_q});

    // Multiply keeps the multiplier in accLo and shifts the product in from the
    // top; divide keeps the dividend in accLo and shifts quotient bits in below.
    always_comb begin
        accHi_d = accHi_q;
        accLo_d = accLo_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        negA_d  = negA_q;
        negB_d  = negB_q;
        isDiv_d = isDiv_q;
        if (load_i) begin
            accHi_d = '0;
            accLo_d = is_div_i ? absA : absB;
            opnd_d  = is_div_i ? absB : absA;
            cnt_d   = '0;
            negA_d  = signed_i && a_i[WIDTH-1];
            negB_d  = signed_i && b_i[WIDTH-1];
            isDiv_d = is_div_i;
        end else if (clear_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            if (isDiv_q) begin
                accHi_d = divGe ? divDiff[WIDTH-1:0] : divTrial[WIDTH-1:0];
                accLo_d = {accLo_q[WIDTH-2:0], divGe};
            end else begin
                accHi_d = mulSum[WIDTH:1];
                accLo_d = {mulSum[0], accLo_q[WIDTH-1:1]};
            end
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accHi_q <= '0;
            accLo_q <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
            negA_q  <= 1'b0;
            negB_q  <= 1'b0;
            isDiv_q <= 1'b0;
        end else begin
            accHi_q <= accHi_d;
            accLo_q <= accLo_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
            negA_q  <= negA_d;
            negB_q  <= negB_d;
            isDiv_q <= isDiv_d;
        end
    end

    assign step_done_o = (cnt_q == LAST);
    assign neg_a_o     = negA_q;
    assign neg_b_o     = negB_q;
    assign result_o    = {accHi_q, accLo_q};

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle MIPS-lite HI/LO multiply/divide unit: control FSM, busy/done
// handshake, sign fixup and the architectural HI/LO registers.
module hilo_muldiv_unit
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [MD_OP_LENGTH-1:0] op,
    input  logic [WIDTH-1:0]        a,
    input  logic [WIDTH-1:0]        b,
    input  logic                    flush,
    output logic                    busy,
    output logic                    done,
    output logic [WIDTH-1:0]        hi,
    output logic [WIDTH-1:0]        lo,
    output logic [WIDTH-1:0]        rdata
);

    md_state_e state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             isDiv_q, isDiv_d;
    logic             divZero_q, divZero_d;
    logic [WIDTH-1:0] aOrig_q, aOrig_d;

    logic               coreLoad, coreRun, coreClear;
    logic               coreSigned;
    logic               stepDone, negA, negB;
    logic [2*WIDTH-1:0] coreResult;

    logic [2*WIDTH-1:0] mulFixed;
    logic [WIDTH-1:0]   quoFixed, remFixed;
    logic [WIDTH-1:0]   fixHi, fixLo;

    assign coreSigned = SIGNED_EN && isSignedOp(op);

    md_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk         (clk),
        .rst         (rst),
        .load_i      (coreLoad),
        .signed_i    (coreSigned),
        .is_div_i    (isDivOp(op)),
        .run_i       (coreRun),
        .clear_i     (coreClear),
        .a_i         (a),
        .b_i         (b),
        .step_done_o (stepDone),
        .neg_a_o     (negA),
        .neg_b_o     (negB),
        .result_o    (coreResult)
    );

    // Quotient takes the XOR of the operand signs, remainder follows the
    // dividend; a zero divisor bypasses fixup so HI returns the raw dividend.
    always_comb begin
        mulFixed = (negA ^ negB) ? (~coreResult + 1'b1) : coreResult;
        quoFixed = (negA ^ negB) ? (~coreResult[WIDTH-1:0] + 1'b1)
                                 : coreResult[WIDTH-1:0];
        remFixed = negA ? (~coreResult[2*WIDTH-1:WIDTH] + 1'b1)
                        : coreResult[2*WIDTH-1:WIDTH];
        fixHi = mulFixed[2*WIDTH-1:WIDTH];
        fixLo = mulFixed[WIDTH-1:0];
        if (isDiv_q) begin
            fixHi = divZero_q ? aOrig_q : remFixed;
            fixLo = divZero_q ? '1 : quoFixed;
        end
    end

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        isDiv_d   = isDiv_q;
        divZero_d = divZero_q;
        aOrig_d   = aOrig_q;
        coreLoad  = 1'b0;
        coreRun   = 1'b0;
        coreClear = 1'b0;
        case (state_q)
            MD_ST_IDLE: begin
                if (start && !flush) begin
                    if (isMulDivOp(op)) begin
                        coreLoad  = 1'b1;
                        isDiv_d   = isDivOp(op);
                        divZero_d = (b == '0);
                        aOrig_d   = a;
                        state_d   = MD_ST_RUN;
                    end else if (op == MD_OP_MTHI) begin
                        hi_d = a;
                    end else if (op == MD_OP_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            MD_ST_RUN: begin
                if (flush) begin
                    coreClear = 1'b1;
                    state_d   = MD_ST_IDLE;
                end else begin
                    coreRun = 1'b1;
                    if (stepDone) begin
                        state_d = MD_ST_FIXUP;
                    end
                end
            end
            MD_ST_FIXUP: begin
                state_d = MD_ST_IDLE;
                if (flush) begin
                    coreClear = 1'b1;
                end else begin
                    hi_d   = fixHi;
                    lo_d   = fixLo;
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = MD_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= MD_ST_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            isDiv_q   <= 1'b0;
            divZero_q <= 1'b0;
            aOrig_q   <= '0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            isDiv_q   <= isDiv_d;
            divZero_q <= divZero_d;
            aOrig_q   <= aOrig_d;
        end
    end

    assign busy  = (state_q != MD_ST_IDLE);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign rdata = (op == MD_OP_MFHI) ? hi_q : lo_q;

endmodule
